// File: rtl/water_fill_controller_pkg.sv
// Shared types and constants for the washer water-level path.
// Also used by the load-size detection block.
package water_fill_controller_pkg;

  localparam int LEVEL_W = 10;

  localparam logic [LEVEL_W-1:0] LOAD_SMALL = LEVEL_W'(20);
  localparam logic [LEVEL_W-1:0] LOAD_MED   = LEVEL_W'(50);
  localparam logic [LEVEL_W-1:0] LOAD_LARGE = LEVEL_W'(80);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } wf_state_t;

endpackage

// File: rtl/water_fill_controller_timer.sv
// Saturating phase timer for fill and drain phases.
// expired is high once count has reached LIMIT.
module wm_phase_timer #(
  parameter int unsigned LIMIT = 599,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         expired
);

  assign expired = (count == W'(LIMIT));

  // Count up while enabled, hold at LIMIT, never wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/water_fill_controller.sv
// Tub fill / hold / drain sequencer with phase timeout.
// Outputs are registered and follow the state being entered.
module water_fill_controller
  import water_fill_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 600,
  parameter int unsigned HYSTERESIS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEVEL_W-1:0] target_level,
  input  logic [LEVEL_W-1:0] level_sensor,
  input  logic               drain_req,
  input  logic               abort,
  output logic               valve_open,
  output logic               drain_open,
  output logic               fill_done,
  output logic               drain_done,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  wf_state_t          st;
  logic [LEVEL_W-1:0] tgt;
  logic [LEVEL_W:0]   low_sum;
  logic               need_refill;
  logic               at_target;
  logic               tmr_clear;
  logic               tmr_en;
  logic               tmr_expired;
  logic [TW-1:0]      tmr_count;

  assign state       = st;
  assign low_sum     = {1'b0, level_sensor}
                     + (LEVEL_W+1)'(HYSTERESIS);
  assign need_refill = low_sum < {1'b0, tgt};
  assign at_target   = level_sensor >= tgt;

  // Timer runs only in FILL/DRAIN; zeroed elsewhere and on abort.
  always_comb begin
    tmr_en    = 1'b0;
    tmr_clear = 1'b1;
    if (st == S_FILL || st == S_DRAIN) begin
      tmr_en    = 1'b1;
      tmr_clear = (st == S_FILL) && abort;
    end
  end

  wm_phase_timer #(
    .LIMIT (TIMEOUT_CYCLES - 1),
    .W     (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  // Main sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IDLE;
      tgt        <= '0;
      valve_open <= 1'b0;
      drain_open <= 1'b0;
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
      fault      <= 1'b0;
    end else begin
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start && target_level != '0) begin
            tgt        <= target_level;
            st         <= S_FILL;
            valve_open <= 1'b1;
          end
        end
        S_FILL: begin
          if (abort) begin
            st         <= S_DRAIN;
            valve_open <= 1'b0;
            drain_open <= 1'b1;
          end else if (at_target) begin
            st         <= S_HOLD;
            valve_open <= 1'b0;
            fill_done  <= 1'b1;
          end else if (tmr_expired) begin
            st         <= S_FAULT;
            valve_open <= 1'b0;
            drain_open <= 1'b0;
            fault      <= 1'b1;
          end
        end
        S_HOLD: begin
          if (abort || drain_req) begin
            st         <= S_DRAIN;
            drain_open <= 1'b1;
          end else if (need_refill) begin
            st         <= S_FILL;
            valve_open <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (level_sensor == '0) begin
            st         <= S_IDLE;
            drain_open <= 1'b0;
            drain_done <= 1'b1;
          end else if (tmr_expired) begin
            st         <= S_FAULT;
            drain_open <= 1'b0;
            fault      <= 1'b1;
          end
        end
        S_FAULT: begin
          valve_open <= 1'b0;
          drain_open <= 1'b0;
          fault      <= 1'b1;
        end
        default: begin
          st         <= S_IDLE;
          valve_open <= 1'b0;
          drain_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_water_fill_controller.sv
// Directed-vector bench for water_fill_controller.
// Expected values are hand-derived from the requirements.
module tb_water_fill_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] target_level;
  logic [9:0] level_sensor;
  logic       drain_req;
  logic       abort;
  logic       valve_open;
  logic       drain_open;
  logic       fill_done;
  logic       drain_done;
  logic       fault;
  logic [2:0] state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  water_fill_controller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .target_level (target_level),
    .level_sensor (level_sensor),
    .drain_req    (drain_req),
    .abort        (abort),
    .valve_open   (valve_open),
    .drain_open   (drain_open),
    .fill_done    (fill_done),
    .drain_done   (drain_done),
    .fault        (fault),
    .state        (state)
  );

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag,
                      input int st, input int v,
                      input int d, input int fd,
                      input int dd, input int f);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".valve"}, int'(valve_open), v);
    check({tag, ".drain"}, int'(drain_open), d);
    check({tag, ".fill_done"}, int'(fill_done), fd);
    check({tag, ".drain_done"}, int'(drain_done), dd);
    check({tag, ".fault"}, int'(fault), f);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    target_level = '0;
    level_sensor = '0;
    drain_req = 1'b0;
    abort = 1'b0;
    #1;
    step();
    step();
    outs("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Nominal fill to 300, ramp 10/cycle
    start = 1'b1;
    target_level = 10'd300;
    step();
    outs("start", 1, 1, 0, 0, 0, 0);
    start = 1'b0;
    target_level = 10'd50;
    for (int s = 10; s < 300; s += 10) begin
      level_sensor = 10'(s);
      step();
      check("ramp.state", int'(state), 1);
      check("ramp.valve", int'(valve_open), 1);
    end
    level_sensor = 10'd300;
    step();
    outs("reach", 2, 0, 0, 1, 0, 0);
    step();
    outs("hold", 2, 0, 0, 0, 0, 0);

    // Hysteresis boundary: 296 holds, 295 refills
    level_sensor = 10'd296;
    step();
    outs("h296", 2, 0, 0, 0, 0, 0);
    level_sensor = 10'd295;
    step();
    outs("h295", 1, 1, 0, 0, 0, 0);
    level_sensor = 10'd300;
    step();
    outs("refilled", 2, 0, 0, 1, 0, 0);

    // Drain from HOLD; start during drain ignored
    drain_req = 1'b1;
    step();
    outs("drain", 3, 0, 1, 0, 0, 0);
    drain_req = 1'b0;
    start = 1'b1;
    level_sensor = 10'd250;
    step();
    outs("drain_st", 3, 0, 1, 0, 0, 0);
    start = 1'b0;
    for (int s = 200; s > 0; s -= 50) begin
      level_sensor = 10'(s);
      step();
      check("dramp.drain", int'(drain_open), 1);
    end
    level_sensor = 10'd0;
    step();
    outs("empty", 0, 0, 0, 0, 1, 0);
    step();
    outs("idle", 0, 0, 0, 0, 0, 0);

    // Abort beats target-reached in FILL
    start = 1'b1;
    target_level = 10'd300;
    step();
    start = 1'b0;
    check("pri.fill", int'(state), 1);
    level_sensor = 10'd300;
    abort = 1'b1;
    step();
    outs("pri", 3, 0, 1, 0, 0, 0);
    abort = 1'b0;
    level_sensor = 10'd0;
    step();
    outs("pri.done", 0, 0, 0, 0, 1, 0);

    // Timeout: sensor stuck at 100
    level_sensor = 10'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    check("to.fill", int'(state), 1);
    repeat (599) step();
    outs("to.599", 1, 1, 0, 0, 0, 0);
    step();
    outs("to.600", 4, 0, 0, 0, 0, 1);
    start = 1'b1;
    drain_req = 1'b1;
    abort = 1'b1;
    level_sensor = 10'd0;
    target_level = 10'd100;
    repeat (3) step();
    outs("to.sticky", 4, 0, 0, 0, 0, 1);
    start = 1'b0;
    drain_req = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    step();
    outs("to.reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Reset mid-fill, then zero target ignored
    level_sensor = 10'd0;
    target_level = 10'd300;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid.fill", int'(state), 1);
    reset = 1'b1;
    step();
    outs("mid.reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    target_level = 10'd0;
    start = 1'b1;
    step();
    outs("zero", 0, 0, 0, 0, 0, 0);
    step();
    outs("zero2", 0, 0, 0, 0, 0, 0);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/water_fill_controller.md
WATER_FILL_CONTROLLER -- requirements
Module: water_fill_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 600, is the maximum cycles allowed per fill or drain phase (60 s at 100 ms clk).
REQ-002 Parameter HYSTERESIS, default 4, is the level drop below target, in sensor units, that triggers a refill.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to begin a fill cycle; sampled only in IDLE.
REQ-006 Port target_level, input, 10 bits: unsigned water level from the load-size detection block; latched on accepted start.
REQ-007 Port level_sensor, input, 10 bits: unsigned measured tub level.
REQ-008 Port drain_req, input, 1 bit: request to empty the tub; acted on in HOLD.
REQ-009 Port abort, input, 1 bit: emergency drain; acted on in FILL and HOLD.
REQ-010 Port valve_open, output, 1 bit: inlet valve command.
REQ-011 Port drain_open, output, 1 bit: drain pump command.
REQ-012 Port fill_done, output, 1 bit: one-cycle pulse on reaching target.
REQ-013 Port drain_done, output, 1 bit: one-cycle pulse on reaching empty.
REQ-014 Port fault, output, 1 bit: sticky timeout indication.
REQ-015 Port state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, HOLD, DRAIN and FAULT.
- All outputs are registered.
- Each output reflects the state entered at the same clock edge.
REQ-017 IDLE SHALL accept start only when target_level != 0.
- On acceptance: latch target_level, clear the phase timer, go to FILL.
- start with target_level == 0 is ignored.
REQ-018 FILL SHALL hold valve_open=1 and increment the phase timer every cycle.
REQ-019 In FILL, level_sensor >= latched target (equality counts) SHALL move to HOLD, deassert valve_open and pulse fill_done for 1 cycle.
REQ-020 In HOLD, the FSM SHALL re-enter FILL with the timer cleared when level_sensor + HYSTERESIS < target.
- The sum is computed 11 bits wide, so no wrap occurs.
- fill_done pulses again when the target is re-reached.
REQ-021 In HOLD, drain_req=1 SHALL enter DRAIN; drain_req takes priority over a simultaneous refill condition.
REQ-022 abort=1 in FILL or HOLD SHALL enter DRAIN on the next edge, closing the valve in that same cycle.
- abort takes priority over target-reached and drain_req.
REQ-023 DRAIN SHALL clear the timer on entry, hold drain_open=1, and return to IDLE when level_sensor == 0.
- drain_done pulses for 1 cycle on that transition.
REQ-024 If the phase timer reaches TIMEOUT_CYCLES-1 in FILL or DRAIN without the exit condition, the FSM SHALL enter FAULT.
- If the exit condition and the timeout occur in the same cycle, the exit condition wins.
REQ-025 FAULT SHALL force valve_open=0 and drain_open=0 and keep fault=1 until reset; all inputs are ignored.
REQ-026 start asserted outside IDLE SHALL be ignored, and target_level changes after latching SHALL have no effect.
REQ-027 The timer SHALL saturate and never wrap; its width is $clog2(TIMEOUT_CYCLES).

Reset
REQ-028 On reset=1 at a clock edge, the FSM SHALL enter IDLE regardless of state, including mid-fill, mid-drain or FAULT.
REQ-029 Reset values: valve_open=0, drain_open=0, fill_done=0, drain_done=0, fault=0, state=IDLE, timer=0, latched target=0.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE=0, FILL=1, HOLD=2, DRAIN=3, FAULT=4) and the water-level width constant (10).
- The same package holds the load-size thresholds (20/50/80) shared with the load-size detection block.
REQ-031 The phase timer SHALL be one sub-module, wm_phase_timer, with clear, enable, saturate and an expired flag.

Verification
REQ-032 Nominal fill:
- Stimulus: reset, then start with target=300; ramp sensor 0->300 by 10/cycle.
- Response: valve_open=1 until sensor=300, then HOLD and one fill_done pulse.
REQ-033 Refill:
- Stimulus: in HOLD with target=300, set sensor=296, then sensor=295.
- Response: no action at 296; at 295, FILL and valve_open=1.
REQ-034 Drain:
- Stimulus: in HOLD, pulse drain_req; ramp sensor to 0.
- Response: drain_open=1 until 0, then drain_done pulse and IDLE.
REQ-035 Timeout:
- Stimulus: start with target=300; sensor stuck at 100.
- Response: after 600 cycles, fault=1 and both valves 0; start ignored until reset.
REQ-036 Priority:
- Stimulus: in FILL, assert abort in the same cycle sensor reaches target.
- Response: DRAIN entered and no fill_done pulse.
REQ-037 Reset mid-fill and zero target:
- Stimulus: reset asserted during FILL; then start with target=0.
- Response: all outputs 0 and IDLE at the next edge; start with target=0 keeps IDLE.
